shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_data, req0_shamt, req0_type  input  32/5/2  operand, shift amount, type (00 SLL, 01 SRL, 10 SRA, 11 SRL).
REQ-007 req1_valid, req1_ready, req1_data, req1_shamt, req1_type  same widths and meaning for requester 1.
REQ-008 resp_valid  output  1  registered shift result available.
REQ-009 resp_ready  input  1  consumer accepts result this cycle when high with resp_valid.
REQ-010 resp_data  output  32  shifted result.
REQ-011 resp_id  output  1  index of the requester that issued the result.

Function
REQ-012 The block SHALL contain one 32-bit five-stage barrel shifter (16/8/4/2/1) shared by both requesters; no second shifter instance.
REQ-013 Output register states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-014 can_accept = EMPTY or (FULL and resp_ready); an acceptance happens only when can_accept=1.
REQ-015 Grant is combinational from current req*_valid and last_grant; exactly one reqN_ready high at most, and only for a requester with reqN_valid=1.
REQ-016 reqN_ready SHALL be 0 whenever can_accept=0, regardless of reqN_valid.
REQ-017 On acceptance: selected operands drive the shifter; resp_data, resp_id loaded on the same edge; state -> FULL; resp_valid high the following cycle (latency 1).
REQ-018 FULL with resp_ready=1 and no acceptance -> EMPTY; FULL with resp_ready=1 and acceptance -> stays FULL with new data (throughput 1/cycle).
REQ-019 FULL with resp_ready=0: resp_data, resp_id held stable; no acceptance.
REQ-020 Shift semantics: SLL zero-fill left; SRL zero-fill right; SRA replicate bit 31; type 11 identical to SRL; shamt 0 returns operand unchanged.
REQ-021 last_grant updates to the granted index only on an acceptance; unchanged otherwise.
REQ-022 Requester inputs are sampled only in the acceptance cycle; changes while not ready have no effect.

Reset
REQ-023 On rst assertion, immediately and independent of clk: resp_valid=0, resp_data=0, resp_id=0, state EMPTY, last_grant=1.
REQ-024 Reset mid-operation SHALL discard any held result; no response for it is produced after reset release.
REQ-025 First cycle after reset release SHALL accept requests (can_accept=1).

Configuration
REQ-026 Macro SHIFT_ARB_RR_EN defined: round-robin, priority to the requester not equal to last_grant when both valid.
REQ-027 SHIFT_ARB_RR_EN undefined: fixed priority, requester 0 always wins when both valid; last_grant register still present but unused for arbitration.
REQ-028 Single valid requester SHALL be granted in both configurations.

Verification
REQ-029 req0 SLL data 0x00000001 shamt 4, resp_ready=1 -> next cycle resp_valid=1, resp_data 0x00000010, resp_id 0.
REQ-030 req1 SRA data 0x80000000 shamt 31 -> resp_data 0xFFFFFFFF, resp_id 1; type 11 data 0xF0000000 shamt 4 -> 0x0F000000.
REQ-031 Both valid for 4 cycles, resp_ready=1 -> resp_id 0,1,0,1 with SHIFT_ARB_RR_EN; 0,0,0,0 without.
REQ-032 resp_ready=0 for 3 cycles while FULL -> resp_data/resp_id stable, req0_ready=req1_ready=0; resp_ready=1 with req0 valid -> new result next cycle, no bubble.
REQ-033 rst asserted asynchronously while resp_valid=1 -> resp_valid 0 before next edge; after release, both valid -> requester 0 granted first.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Shift-arbiter bus: two shift requesters and one registered result port.
// The slave modport belongs to the arbiter; the master modport belongs to the environment.
interface shift_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_type;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_type;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_type,
    input  req1_valid, req1_data, req1_shamt, req1_type,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_type,
    output req1_valid, req1_data, req1_shamt, req1_type,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two requesters share one 32-bit barrel shifter feeding a single-entry output register.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
  } shreq_t;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_id_q, resp_id_d;

  logic        can_accept, any_valid, accept, grant_id;
  shreq_t      sel;
  logic        is_sll, fill;
  logic [5:0][31:0] stg;
  logic [31:0] shifted;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  assign can_accept = (state_q == EMPTY) || bus.resp_ready;
  assign any_valid  = bus.req0_valid || bus.req1_valid;
  assign accept     = can_accept && any_valid;

`ifdef SHIFT_ARB_RR_EN
  // On contention, favour whichever requester was not granted last.
  assign grant_id = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign grant_id = !bus.req0_valid;
`endif

  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;

  assign sel = grant_id ? shreq_t'{bus.req1_data, bus.req1_shamt, bus.req1_type}
                        : shreq_t'{bus.req0_data, bus.req0_shamt, bus.req0_type};

  // Left shifts reuse the right shifter by bit-reversing operand and result.
  assign is_sll = (sel.op == 2'b00);
  assign fill   = (sel.op == 2'b10) && sel.data[31];
  assign stg[0] = is_sll ? rev32(sel.data) : sel.data;

  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam int K = 16 >> s;
    assign stg[s+1] = sel.shamt[4-s] ? {{K{fill}}, stg[s][31:K]} : stg[s];
  end

  assign shifted = is_sll ? rev32(stg[5]) : stg[5];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = grant_id;
      resp_data_d  = shifted;
      resp_id_d    = grant_id;
    end else if (state_q == FULL && bus.resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign bus.resp_valid = (state_q == FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: shift semantics, arbitration, backpressure and async reset.
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  shift_arbiter_if bus ();
  shift_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive0(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] t);
    bus.req0_valid = v; bus.req0_data = d; bus.req0_shamt = sh; bus.req0_type = t;
  endtask

  task automatic drive1(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] t);
    bus.req1_valid = v; bus.req1_data = d; bus.req1_shamt = sh; bus.req1_type = t;
  endtask

  task automatic test_reset();
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0); bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.resp_valid); else pass_cnt++;
    chk_cnt++; if (bus.resp_data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.resp_data); else pass_cnt++;
    chk_cnt++; if (bus.resp_id !== 1'b0) $display("FAIL reset_id got %b want 0", bus.resp_id); else pass_cnt++;
    rst = 1'b0;
  endtask

  // One request on a chosen requester, result checked one cycle later.
  task automatic test_shift(input string name, input logic who, input logic [31:0] d,
                            input logic [4:0] sh, input logic [1:0] t, input logic [31:0] exp);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    if (who) drive1(1, d, sh, t); else drive0(1, d, sh, t);
    #1;
    chk_cnt++;
    if ((who ? bus.req1_ready : bus.req0_ready) !== 1'b1)
      $display("FAIL %s_ready got 0 want 1", name);
    else pass_cnt++;
    @(negedge clk);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    chk_cnt++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp || bus.resp_id !== who)
      $display("FAIL %s got v=%b d=%h id=%b want v=1 d=%h id=%b", name, bus.resp_valid, bus.resp_data, bus.resp_id, exp, who);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    logic exp_id [4];
`ifdef SHIFT_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    test_reset();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    drive0(1, 32'hA, 0, 0); drive1(1, 32'hB, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== exp_id[i] || bus.resp_data !== (exp_id[i] ? 32'hB : 32'hA))
        $display("FAIL arb_%0d got v=%b id=%b d=%h want v=1 id=%b", i, bus.resp_valid, bus.resp_id, bus.resp_data, exp_id[i]);
      else pass_cnt++;
    end
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    @(negedge clk);
    chk_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL arb_drain got %b want 0", bus.resp_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    drive0(1, 32'h3, 1, 0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive0(1, 32'h77, 2, 0); drive1(1, 32'h99, 3, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_ready_%0d got %b%b want 00", i, bus.req0_ready, bus.req1_ready);
      else pass_cnt++;
      @(negedge clk);
      drive1(1, 32'h100 + i, 3, 1);
      chk_cnt++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h6 || bus.resp_id !== 1'b0)
        $display("FAIL bp_hold_%0d got v=%b d=%h id=%b want v=1 d=00000006 id=0", i, bus.resp_valid, bus.resp_data, bus.resp_id);
      else pass_cnt++;
    end
    drive1(0, 0, 0, 0);
    drive0(1, 32'h5, 0, 0);
    bus.resp_ready = 1'b1;
    #1;
    chk_cnt++; if (bus.req0_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bus.req0_ready); else pass_cnt++;
    @(negedge clk);
    drive0(0, 0, 0, 0);
    chk_cnt++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h5 || bus.resp_id !== 1'b0)
      $display("FAIL bp_next got v=%b d=%h id=%b want v=1 d=00000005 id=0", bus.resp_valid, bus.resp_data, bus.resp_id);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive1(1, 32'hDEAD, 0, 0);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 1'b0)
      $display("FAIL async_rst got v=%b d=%h id=%b want v=0 d=0 id=0", bus.resp_valid, bus.resp_data, bus.resp_id);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL post_rst_stale got %b want 0", bus.resp_valid); else pass_cnt++;
    drive0(1, 32'h1, 1, 0); drive1(1, 32'h2, 1, 0);
    #1;
    chk_cnt++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL post_rst_grant got %b%b want 10", bus.req0_ready, bus.req1_ready);
    else pass_cnt++;
    @(negedge clk);
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    chk_cnt++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'h2)
      $display("FAIL post_rst_resp got v=%b id=%b d=%h want v=1 id=0 d=00000002", bus.resp_valid, bus.resp_id, bus.resp_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_shift("sll4",      1'b0, 32'h00000001, 5'd4,  2'b00, 32'h00000010);
    test_shift("sra31",     1'b1, 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF);
    test_shift("type11",    1'b1, 32'hF0000000, 5'd4,  2'b11, 32'h0F000000);
    test_shift("srl31",     1'b0, 32'h80000000, 5'd31, 2'b01, 32'h00000001);
    test_shift("sll0",      1'b1, 32'h12345678, 5'd0,  2'b00, 32'h12345678);
    test_shift("sll31",     1'b0, 32'hFFFFFFFF, 5'd31, 2'b00, 32'h80000000);
    test_shift("sra_pos",   1'b0, 32'h40000000, 5'd4,  2'b10, 32'h04000000);
    test_shift("sra_neg",   1'b1, 32'h8000F000, 5'd12, 2'b10, 32'hFFF8000F);
    test_shift("srl_mix",   1'b0, 32'hA5A5A5A5, 5'd7,  2'b01, 32'h014B4B4B);
    test_shift("sll_mix",   1'b1, 32'hA5A5A5A5, 5'd9,  2'b00, 32'h4B4B4A00);
    test_arbitration();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
